dmem_mmio: RTL and testbench

- Data-side memory subsystem directly downstream of the core's MEM-stage RAM port.
- Consumes ramwe/ramwaddr/ramwdata/ramre/ramraddr and returns ramdata in the same cycle.
- Decodes addresses into a word RAM, a UART transmitter (FIFO plus 8N1 serializer) and a free-running cycle counter.
- Sits beside the instruction ROM at top level; the core has no stall input, so every access completes in zero wait states.

---
 rtl/dmem_mmio_pkg.sv | 23 ++
 rtl/dmem_mmio_if.sv | 22 ++
 rtl/dmem_mmio_uart_tx.sv | 126 ++++++++++++
 rtl/dmem_mmio.sv | 114 +++++++++++
 tb/tb_dmem_mmio.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio shared definitions: bus widths, MMIO offsets, STATUS bits, serializer states.
package dmem_mmio_pkg;

  localparam int unsigned DataBus     = 32;
  localparam int unsigned DataAddrBus = 32;

  localparam logic [DataAddrBus-1:0] OFFS_TXDATA = 32'h0000_0000;
  localparam logic [DataAddrBus-1:0] OFFS_STATUS = 32'h0000_0004;
  localparam logic [DataAddrBus-1:0] OFFS_CYCLE  = 32'h0000_0008;

  localparam int unsigned STAT_FULL   = 0;
  localparam int unsigned STAT_EMPTY  = 1;
  localparam int unsigned STAT_ACTIVE = 2;
  localparam int unsigned STAT_OVF    = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// Core MEM-stage data port: write strobe/address/data, read strobe/address, same-cycle read data.
interface dmem_mmio_if;
  import dmem_mmio_pkg::*;

  logic                   ramwe;
  logic [DataAddrBus-1:0] ramwaddr;
  logic [DataBus-1:0]     ramwdata;
  logic                   ramre;
  logic [DataAddrBus-1:0] ramraddr;
  logic [DataBus-1:0]     ramdata;

  modport master (
    output ramwe, ramwaddr, ramwdata, ramre, ramraddr,
    input  ramdata
  );

  modport slave (
    input  ramwe, ramwaddr, ramwdata, ramre, ramraddr,
    output ramdata
  );

endinterface

// File: rtl/dmem_mmio_uart_tx.sv
// UART transmitter: TX FIFO plus 8N1 serializer.
module uart_tx
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       active,
  output logic       tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;

  tx_state_e     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic          pop;
  logic          push_ok;
  logic          baud_done;

  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign active    = (state_q != TX_IDLE);
  assign tx        = tx_q;
  assign pop       = (state_q == TX_IDLE) && !empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign baud_done = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= fifo_q[rd_ptr_q];
            state_q <= TX_START;
            tx_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= TX_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory subsystem: word RAM, UART TX and cycle counter behind a zero-wait-state port.
// Optional cycle counter enabled by `define DMEM_MMIO_CYCLE_EN.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned      RAM_DEPTH    = 1024,
  parameter int unsigned      FIFO_DEPTH   = 8,
  parameter int unsigned      CLKS_PER_BIT = 868,
  parameter logic [31:0]      MMIO_BASE    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  dmem_mmio_if.slave  bus,
  output logic        uart_tx,
  output logic        uart_busy
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam logic [31:0] ADDR_TXDATA = MMIO_BASE + OFFS_TXDATA;
  localparam logic [31:0] ADDR_STATUS = MMIO_BASE + OFFS_STATUS;
  localparam logic [31:0] ADDR_CYCLE  = MMIO_BASE + OFFS_CYCLE;

  logic [DataBus-1:0] ram_q [RAM_DEPTH];
  logic               overflow_q;

  logic               w_ram, w_txdata;
  logic               r_ram, r_status, r_cycle;
  logic [AW-1:0]      w_idx, r_idx;
  logic               fifo_full, fifo_empty, tx_active;
  logic [DataBus-1:0] status;
  logic [DataBus-1:0] cycle_rd;
  logic               unused_addr_bits;

  assign w_ram    = (bus.ramwaddr[31:AW+2] == '0);
  assign r_ram    = (bus.ramraddr[31:AW+2] == '0);
  assign w_idx    = bus.ramwaddr[AW+1:2];
  assign r_idx    = bus.ramraddr[AW+1:2];
  assign w_txdata = (bus.ramwaddr[31:2] == ADDR_TXDATA[31:2]);
  assign r_status = (bus.ramraddr[31:2] == ADDR_STATUS[31:2]);
  assign r_cycle  = (bus.ramraddr[31:2] == ADDR_CYCLE[31:2]);

  assign unused_addr_bits = ^{bus.ramwaddr[1:0], bus.ramraddr[1:0]};

  uart_tx #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ramwe && w_txdata),
    .push_data (bus.ramwdata[7:0]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .active    (tx_active),
    .tx        (uart_tx)
  );

  assign uart_busy = !fifo_empty || tx_active;

  always_ff @(posedge clk) begin
    if (bus.ramwe && w_ram) begin
      ram_q[w_idx] <= bus.ramwdata;
    end
  end

  // The serializer pops only from IDLE, so a push into a full FIFO is lost exactly when it is active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (bus.ramwe && w_txdata && fifo_full && tx_active) begin
      overflow_q <= 1'b1;
    end else if (bus.ramre && r_status) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef DMEM_MMIO_CYCLE_EN
  logic [31:0] cycle_q;
  logic        w_cycle;

  assign w_cycle  = (bus.ramwaddr[31:2] == ADDR_CYCLE[31:2]);
  assign cycle_rd = cycle_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (bus.ramwe && w_cycle) begin
      cycle_q <= bus.ramwdata;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    status              = '0;
    status[STAT_FULL]   = fifo_full;
    status[STAT_EMPTY]  = fifo_empty;
    status[STAT_ACTIVE] = tx_active;
    status[STAT_OVF]    = overflow_q;
  end

  always_comb begin
    bus.ramdata = '0;
    if (rst && bus.ramre) begin
      if (r_ram)         bus.ramdata = ram_q[r_idx];
      else if (r_status) bus.ramdata = status;
      else if (r_cycle)  bus.ramdata = cycle_rd;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CY = BASE + 32'h8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_tx;
  logic uart_busy;

  dmem_mmio_if bif ();

  dmem_mmio #(
    .RAM_DEPTH    (1024),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4),
    .MMIO_BASE    (32'h1000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .uart_tx   (uart_tx),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        re;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
    bif.ramwe    = we;
    bif.ramwaddr = wa;
    bif.ramwdata = wd;
    bif.ramre    = re;
    bif.ramraddr = ra;
  endtask

  // Waits for a start bit, then samples mid-bit; ok=0 on timeout or bad framing.
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int waited = 0;
    b  = '0;
    ok = 1'b0;
    while (uart_tx !== 1'b0 && waited < 300) begin
      tick();
      waited++;
    end
    if (uart_tx === 1'b0) begin
      ok = 1'b1;
      repeat (2) tick();
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (4) tick();
        b[k] = uart_tx;
      end
      repeat (4) tick();
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    int         lows;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0013, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0010, 32'h0000_0001};
    vecs[5]  = '{1'b1, 32'h2000_0000, 32'hAAAA_AAAA, 1'b1, 32'h2000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h1000_000C, 32'h0000_0055, 1'b1, 32'h1000_000C, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h2000_0010, 32'hBAD0_BAD0, 1'b1, 32'h0000_0010, 32'h0000_0001};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0077, 1'b1, 32'h0000_0010, 32'h0000_0001};
    vecs[9]  = '{1'b1, 32'h0000_1000, 32'h0000_0099, 1'b1, 32'h0000_0000, 32'h0000_0077};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b1, 32'h0000_1000, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0FFC, 32'h1234_5678};
    vecs[12] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 32'h0000_0077};
    vecs[13] = '{1'b1, A_ST,          32'hFFFF_FFFF, 1'b1, A_ST,          32'h0000_0002};
    vecs[14] = '{1'b0, 32'h0,         32'h0,         1'b1, A_ST,          32'h0000_0002};
    vecs[15] = '{1'b0, 32'h0,         32'h0,         1'b1, A_TX,          32'h0000_0000};
    vecs[16] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0010, 32'h0000_0000};
    vecs[17] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0010, 32'h0000_0001};

    // Reset state
    drive(1'b0, 32'h0, 32'h0, 1'b1, A_ST);
    repeat (3) tick();
    check("reset_tx", uart_tx, 1'b1);
    check("reset_busy", uart_busy, 1'b0);
    check("reset_rdata_gated", bif.ramdata, 32'h0);
    rst = 1'b1;
    #2;
    check("reset_status", bif.ramdata, 32'h2);
    tick();

    // RAM and decode vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      #2;
      check($sformatf("vec%0d_rdata", i), bif.ramdata, vecs[i].exp);
      tick();
    end
    check("vec_idle_busy", uart_busy, 1'b0);

    // Single frame 0x55
    drive(1'b1, A_TX, 32'h0000_0055, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("frame_pre_tx", uart_tx, 1'b1);
    check("frame_pre_busy", uart_busy, 1'b1);
    exp_b = 8'h55;
    for (int s = 0; s < 40; s++) begin
      logic e;
      tick();
      if (s < 4)       e = 1'b0;
      else if (s < 36) e = exp_b[(s - 4) / 4];
      else             e = 1'b1;
      check($sformatf("frame_tx_s%0d", s), uart_tx, e);
      check($sformatf("frame_busy_s%0d", s), uart_busy, 1'b1);
    end
    tick();
    check("frame_post_busy", uart_busy, 1'b0);
    check("frame_post_tx", uart_tx, 1'b1);

    // FIFO burst with overflow
    fork
      begin
        logic [7:0] b;
        bit         ok;
        for (int j = 0; j < 5; j++) begin
          rx_byte(b, ok);
          check($sformatf("burst_rx%0d_ok", j), 32'(ok), 32'h1);
          check($sformatf("burst_rx%0d_data", j), 32'(b), 32'(j + 1));
        end
      end
      begin
        for (int i = 1; i <= 6; i++) begin
          drive(1'b1, A_TX, 32'(i), 1'b0, 32'h0);
          tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, A_ST);
        #2;
        check("burst_status1", bif.ramdata, 32'h0000_000D);
        tick();
        #2;
        check("burst_status2", bif.ramdata, 32'h0000_0005);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      end
    join
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("burst_no_sixth_frame", 32'(lows), 32'h0);
    check("burst_end_busy", uart_busy, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, A_ST);
    #2;
    check("burst_end_status", bif.ramdata, 32'h2);
    tick();

    // Cycle counter
    drive(1'b1, A_CY, 32'hFFFF_FFFE, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, A_CY);
`ifdef DMEM_MMIO_CYCLE_EN
    #2; check("cycle_0", bif.ramdata, 32'hFFFF_FFFE); tick();
    #2; check("cycle_1", bif.ramdata, 32'hFFFF_FFFF); tick();
    #2; check("cycle_2", bif.ramdata, 32'h0000_0000); tick();
    #2; check("cycle_3", bif.ramdata, 32'h0000_0001); tick();
`else
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("cycle_off_%0d", c), bif.ramdata, 32'h0);
      tick();
    end
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset during DATA bit 3 with two bytes queued
    drive(1'b1, A_TX, 32'h0000_00A5, 1'b0, 32'h0); tick();
    drive(1'b1, A_TX, 32'h0000_003C, 1'b0, 32'h0); tick();
    drive(1'b1, A_TX, 32'h0000_000F, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (16) tick();
    check("midrst_bit3", uart_tx, 1'b0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0010);
    #2;
    check("midrst_rdata_gated", bif.ramdata, 32'h0);
    tick();
    check("midrst_tx", uart_tx, 1'b1);
    check("midrst_busy", uart_busy, 1'b0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, A_ST);
    #2;
    check("midrst_status", bif.ramdata, 32'h2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0010);
    #2;
    check("midrst_ram_kept", bif.ramdata, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (uart_tx !== 1'b1 || uart_busy !== 1'b0) lows++;
    end
    check("midrst_no_frames", 32'(lows), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
